// File: rtl/segre_pkg.sv
// segre_pkg: shared widths, trap cause codes, CSR addresses and trap-controller enums
package segre_pkg;
  localparam int ADDR_SIZE = 32;
  localparam int WORD_SIZE = 32;
  localparam int CSR_SIZE  = 12;
  localparam logic [WORD_SIZE-1:0] ILLEGAL_INSTR     = 32'd2;
  localparam logic [WORD_SIZE-1:0] LOAD_ACCESS_FAULT = 32'd5;
  localparam logic [CSR_SIZE-1:0]  CSR_SIE           = 12'h104;
  localparam logic [CSR_SIZE-1:0]  CSR_PRIV          = 12'h7c0;
  typedef enum logic [2:0] {IDLE, DRAIN, COMMIT, REDIRECT, SRET_SIE, SRET_PRIV, HALT} trap_state_e;
  typedef enum logic {TRAP, RET} trap_kind_e;
endpackage

// File: rtl/segre_trap_prio.sv
// segre_trap_prio: picks one trap source per cycle, mem fault > illegal instr > sret
module segre_trap_prio
  import segre_pkg::*;
(
  input  logic                 mem_exc,
  input  logic [ADDR_SIZE-1:0] mem_pc,
  input  logic [ADDR_SIZE-1:0] mem_addr,
  input  logic                 dec_exc,
  input  logic [ADDR_SIZE-1:0] dec_pc,
  input  logic                 sret,
  output logic                 valid,
  output trap_kind_e           kind,
  output logic [ADDR_SIZE-1:0] pc,
  output logic [ADDR_SIZE-1:0] addr,
  output logic [WORD_SIZE-1:0] cause
);
  always_comb begin
    valid = mem_exc | dec_exc | sret;
    kind  = (mem_exc | dec_exc) ? TRAP : RET;
    pc    = mem_exc ? mem_pc : dec_exc ? dec_pc : '0;
    addr  = mem_exc ? mem_addr : '0;
    cause = mem_exc ? LOAD_ACCESS_FAULT : dec_exc ? ILLEGAL_INSTR : '0;
  end
endmodule

// File: rtl/segre_trap_ctrl.sv
// segre_trap_ctrl: trap/SRET sequencer in front of the CSR file (drain, commit, redirect, fatal halt).
// Define SEGRE_TRAP_STATS_EN to build the trap/sret statistics counters.
module segre_trap_ctrl
  import segre_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 mem_exc_i,
  input  logic [ADDR_SIZE-1:0] mem_pc_i,
  input  logic [ADDR_SIZE-1:0] mem_addr_i,
  input  logic                 dec_exc_i,
  input  logic [ADDR_SIZE-1:0] dec_pc_i,
  input  logic                 sret_i,
  input  logic                 mem_idle_i,
  input  logic                 fetch_ready_i,
  input  logic                 sie_i,
  input  logic [WORD_SIZE-1:0] csr_stvec_i,
  input  logic [WORD_SIZE-1:0] csr_sepc_i,
  input  logic                 pl_csr_we_i,
  input  logic [CSR_SIZE-1:0]  pl_csr_waddr_i,
  input  logic [WORD_SIZE-1:0] pl_csr_data_i,
  output logic                 csr_we_o,
  output logic [CSR_SIZE-1:0]  csr_waddr_o,
  output logic [WORD_SIZE-1:0] csr_data_o,
  output logic                 pp_exc_o,
  output logic [ADDR_SIZE-1:0] pc_exc_o,
  output logic [ADDR_SIZE-1:0] addr_exc_o,
  output logic [WORD_SIZE-1:0] cause_o,
  output logic                 flush_o,
  output logic                 redirect_valid_o,
  output logic [ADDR_SIZE-1:0] redirect_pc_o,
  output logic                 halted_o,
  output logic [31:0]          trap_count_o,
  output logic [31:0]          sret_count_o
);
  localparam int CW = $clog2(DRAIN_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_TIMEOUT - 1);
  trap_state_e          state, state_nxt;
  trap_kind_e           kind, p_kind;
  logic                 p_valid;
  logic [ADDR_SIZE-1:0] p_pc, p_addr;
  logic [WORD_SIZE-1:0] p_cause;
  logic [CW-1:0]        cnt;
  logic                 idle;
  segre_trap_prio u_prio (
    .mem_exc  (mem_exc_i),
    .mem_pc   (mem_pc_i),
    .mem_addr (mem_addr_i),
    .dec_exc  (dec_exc_i),
    .dec_pc   (dec_pc_i),
    .sret     (sret_i),
    .valid    (p_valid),
    .kind     (p_kind),
    .pc       (p_pc),
    .addr     (p_addr),
    .cause    (p_cause)
  );
  always_ff @(posedge clk_i or negedge rsn_i)
    if (!rsn_i) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = !p_valid ? IDLE : (p_kind == RET || sie_i) ? DRAIN : HALT;
      DRAIN:     state_nxt = mem_idle_i ? (kind == TRAP ? COMMIT : SRET_SIE) : cnt == CNT_LAST ? HALT : DRAIN;
      COMMIT:    state_nxt = REDIRECT;
      SRET_SIE:  state_nxt = SRET_PRIV;
      SRET_PRIV: state_nxt = REDIRECT;
      REDIRECT:  state_nxt = fetch_ready_i ? IDLE : REDIRECT;
      HALT:      state_nxt = HALT;
      default:   state_nxt = IDLE;
    endcase
    idle             = state == IDLE;
    flush_o          = !idle;
    pp_exc_o         = state == COMMIT;
    halted_o         = state == HALT;
    redirect_valid_o = state == REDIRECT;
    redirect_pc_o    = state != REDIRECT ? '0 : ADDR_SIZE'(kind == TRAP ? csr_stvec_i : csr_sepc_i);
    // pipeline writes pass only when idle and out of reset; SRET owns the port otherwise
    csr_we_o    = idle ? pl_csr_we_i & rsn_i : state == SRET_SIE || state == SRET_PRIV;
    csr_waddr_o = idle ? (rsn_i ? pl_csr_waddr_i : '0) : state == SRET_SIE ? CSR_SIE : state == SRET_PRIV ? CSR_PRIV : '0;
    csr_data_o  = idle ? (rsn_i ? pl_csr_data_i : '0) : state == SRET_SIE ? WORD_SIZE'(1) : '0;
  end
  always_ff @(posedge clk_i or negedge rsn_i)
    if (!rsn_i) begin
      kind       <= TRAP;
      pc_exc_o   <= '0;
      addr_exc_o <= '0;
      cause_o    <= '0;
    end else if (idle && p_valid) begin
      kind <= p_kind;
      if (p_kind == TRAP && sie_i) begin
        pc_exc_o   <= p_pc;
        addr_exc_o <= p_addr;
        cause_o    <= p_cause;
      end
    end
  always_ff @(posedge clk_i or negedge rsn_i)
    if (!rsn_i) cnt <= '0;
    else cnt <= state == DRAIN ? cnt + 1'b1 : '0;
`ifdef SEGRE_TRAP_STATS_EN
  always_ff @(posedge clk_i or negedge rsn_i)
    if (!rsn_i) begin
      trap_count_o <= '0;
      sret_count_o <= '0;
    end else begin
      if (state == COMMIT) trap_count_o <= trap_count_o + 1'b1;
      if (state == SRET_PRIV) sret_count_o <= sret_count_o + 1'b1;
    end
`else
  assign trap_count_o = '0;
  assign sret_count_o = '0;
`endif
endmodule
